// File: rtl/fll_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fll_cfg_ctrl
//  Description : Bridges a req/gnt/rvalid register port onto the FLL
//                configuration handshake (CFGREQ/CFGACK). CFGACK is
//                resynchronised, a minimum handshake window rejects stale
//                ACKs, a timeout aborts hung accesses and an idle gap is
//                enforced after every response.
//  Revision    : 1.0 - initial release
// ============================================================================
module fll_cfg_ctrl #(
    parameter int CFG_ADDR_WIDTH = 4,
    parameter int CFG_DATA_WIDTH = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT        = 64,
    parameter int GAP_CYCLES     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // register port
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [CFG_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [CFG_DATA_WIDTH-1:0] wdata_i,
    output logic                      rvalid_o,
    output logic [CFG_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic                      busy_o,
    // FLL configuration interface
    output logic                      fll_cfgreq_o,
    input  logic                      fll_cfgack_i,
    output logic [CFG_ADDR_WIDTH-1:0] fll_cfgad_o,
    output logic [CFG_DATA_WIDTH-1:0] fll_cfgd_o,
    input  logic [CFG_DATA_WIDTH-1:0] fll_cfgq_i,
    output logic                      fll_cfgweb_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TW-1:0] c_MIN_WIN   = TW'(SYNC_STAGES);
    localparam logic [TW-1:0] c_TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] c_TIMER_MAX = {TW{1'b1}};
    localparam logic [GW-1:0] c_GAP_LAST  = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [SYNC_STAGES-1:0]   r_ack_sync;
    logic                     w_ack_s;
    logic [TW-1:0]            r_timer;
    logic [GW-1:0]            r_gap_cnt;
    logic                     w_grant;
    logic                     w_ack_take;
    logic                     w_timeout;

    assign w_ack_s  = r_ack_sync[SYNC_STAGES-1];
    assign gnt_o    = w_grant;
    assign rvalid_o = (r_state == ST_RESP);
    assign busy_o   = (r_state != ST_IDLE);

    // CFGACK synchroniser: shift the asynchronous level through SYNC_STAGES flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], fll_cfgack_i};
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; ACK takes priority over the timeout in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_ack_take  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_grant = req_i;
                if (req_i) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_ack_s && (r_timer >= c_MIN_WIN)) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (r_timer == c_TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request launch, handshake window timer and response capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fll_cfgreq_o <= 1'b0;
            fll_cfgad_o  <= '0;
            fll_cfgd_o   <= '0;
            fll_cfgweb_o <= 1'b1;
            rdata_o      <= '0;
            err_o        <= 1'b0;
            r_timer      <= '0;
        end else begin
            if (w_grant) begin
                fll_cfgad_o  <= addr_i;
                fll_cfgd_o   <= wdata_i;
                fll_cfgweb_o <= ~we_i;
                fll_cfgreq_o <= 1'b1;
                r_timer      <= '0;
            end else if (r_state == ST_REQ && r_timer != c_TIMER_MAX) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_ack_take) begin
                fll_cfgreq_o <= 1'b0;
                rdata_o      <= fll_cfgweb_o ? fll_cfgq_i : '0;
                err_o        <= 1'b0;
            end else if (w_timeout) begin
                fll_cfgreq_o <= 1'b0;
                rdata_o      <= '0;
                err_o        <= 1'b1;
            end
        end
    end

    // Post-response idle gap counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gap_cnt <= '0;
        end else if (r_state == ST_RESP) begin
            r_gap_cnt <= '0;
        end else if (r_state == ST_GAP) begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
        end
    end

endmodule
`default_nettype wire
